// File: rtl/sram_spi_arbiter.sv
// sram_spi_arbiter
// Shares one SPI serial SRAM between two byte-wide requesters (port 0: CPU,
// port 1: UART loader). Each access is one SPI frame: opcode, address, data,
// all MSB first, mode 0, two system clocks per serial bit.
//
// Ports
//   clk               system clock, everything on the rising edge
//   reset             synchronous, active-low
//   pN_req            access request, held until pN_ack
//   pN_we             1 = byte write, 0 = byte read
//   pN_addr           byte address (ADDR_W bits)
//   pN_wdata          write byte
//   pN_rdata          read byte, valid while pN_ack is high, kept afterwards
//   pN_ack            one-cycle completion pulse
//   sclk              SPI clock, idle low
//   sram_ce           SRAM chip enable, active low
//   si                serial data to SRAM
//   so                serial data from SRAM
//   busy              high whenever the FSM is not idle
module sram_spi_arbiter #(
  parameter int unsigned ADDR_W    = 16,
  parameter logic [7:0]  CMD_READ  = 8'h03,
  parameter logic [7:0]  CMD_WRITE = 8'h02
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [7:0]        p0_wdata,
  output logic [7:0]        p0_rdata,
  output logic              p0_ack,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [7:0]        p1_wdata,
  output logic [7:0]        p1_rdata,
  output logic              p1_ack,
  output logic              sclk,
  output logic              sram_ce,
  output logic              si,
  input  logic              so,
  output logic              busy
);

  // Frame length in bits and the width of the half-bit counter.
  localparam int unsigned N  = 16 + ADDR_W;
  localparam int unsigned CW = $clog2(2 * N);
  localparam logic [CW-1:0] LAST_CNT = CW'(2 * N - 1);
  // Index of the first data bit within the frame.
  localparam logic [CW-2:0] DATA_IDX = (CW - 1)'(8 + ADDR_W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, GAP} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [N-1:0]    frame_q;
  logic [6:0]      rxByte_q;
  logic            gnt_q;
  logic            lastGnt_q;
  logic            we_q;
  logic            sclk_q;
  logic            ce_q;
  logic            si_q;
  logic            p0Ack_q;
  logic            p1Ack_q;
  logic [7:0]      p0Rdata_q;
  logic [7:0]      p1Rdata_q;

  logic            gnt_d;
  logic            selWe;
  logic [N-1:0]    frame_d;
  logic [CW-1:0]   cnt_d;
  logic [7:0]      rx_d;
  logic            dataSample;

  // Round-robin choice: on a tie the port not granted last wins, a lone
  // requester always wins. The full frame for the chosen port is built here
  // so it can be latched in one step; read frames carry zeros in the data
  // field so si stays low while the SRAM answers.
  always_comb begin
    gnt_d = 1'b0;
    if (p0_req && p1_req) begin
      gnt_d = ~lastGnt_q;
    end else if (p1_req) begin
      gnt_d = 1'b1;
    end
    selWe = gnt_d ? p1_we : p0_we;
    if (gnt_d) begin
      frame_d = {(p1_we ? CMD_WRITE : CMD_READ), p1_addr, (p1_we ? p1_wdata : 8'h00)};
    end else begin
      frame_d = {(p0_we ? CMD_WRITE : CMD_READ), p0_addr, (p0_we ? p0_wdata : 8'h00)};
    end
  end

  // Half-bit bookkeeping: odd counts are phase 1 (sclk high); so is sampled
  // at the end of phase 1 of each data bit, and the byte assembled so far
  // plus the current so bit forms the result on the final half-bit.
  always_comb begin
    cnt_d      = cnt_q + CW'(1);
    rx_d       = {rxByte_q, so};
    dataSample = cnt_q[0] && (cnt_q[CW-1:1] >= DATA_IDX);
  end

  // Main FSM. All SPI pins and acks are registered here so they change only
  // on clock edges. The frame is held in a shift register: its MSB is moved
  // to si at the start of every bit (entry into SHIFT and each phase-1 to
  // phase-0 transition).
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      frame_q   <= '0;
      rxByte_q  <= '0;
      gnt_q     <= 1'b0;
      lastGnt_q <= 1'b1;
      we_q      <= 1'b0;
      sclk_q    <= 1'b0;
      ce_q      <= 1'b1;
      si_q      <= 1'b0;
      p0Ack_q   <= 1'b0;
      p1Ack_q   <= 1'b0;
      p0Rdata_q <= 8'h00;
      p1Rdata_q <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (p0_req || p1_req) begin
            state_q   <= SHIFT;
            gnt_q     <= gnt_d;
            lastGnt_q <= gnt_d;
            we_q      <= selWe;
            cnt_q     <= '0;
            ce_q      <= 1'b0;
            sclk_q    <= 1'b0;
            si_q      <= frame_d[N-1];
            frame_q   <= frame_d << 1;
          end
        end
        SHIFT: begin
          if (dataSample) begin
            rxByte_q <= rx_d[6:0];
          end
          if (cnt_q == LAST_CNT) begin
            state_q <= DONE;
            ce_q    <= 1'b1;
            sclk_q  <= 1'b0;
            si_q    <= 1'b0;
            if (gnt_q) begin
              p1Ack_q <= 1'b1;
              if (!we_q) begin
                p1Rdata_q <= rx_d;
              end
            end else begin
              p0Ack_q <= 1'b1;
              if (!we_q) begin
                p0Rdata_q <= rx_d;
              end
            end
          end else begin
            cnt_q  <= cnt_d;
            sclk_q <= cnt_d[0];
            if (cnt_q[0]) begin
              si_q    <= frame_q[N-1];
              frame_q <= frame_q << 1;
            end
          end
        end
        DONE: begin
          p0Ack_q <= 1'b0;
          p1Ack_q <= 1'b0;
          state_q <= GAP;
        end
        GAP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sclk     = sclk_q;
  assign sram_ce  = ce_q;
  assign si       = si_q;
  assign p0_ack   = p0Ack_q;
  assign p1_ack   = p1Ack_q;
  assign p0_rdata = p0Rdata_q;
  assign p1_rdata = p1Rdata_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sram_spi_arbiter.sv
// tb_sram_spi_arbiter
// Bench for sram_spi_arbiter with a behavioural SPI SRAM attached. Covers
// reset values, a round-robin tie, a table of single-port accesses, a
// continuous two-port contention, and a reset that aborts a write frame.
module tb_sram_spi_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        p0_req = 1'b0, p1_req = 1'b0;
  logic        p0_we = 1'b0, p1_we = 1'b0;
  logic [15:0] p0_addr = '0, p1_addr = '0;
  logic [7:0]  p0_wdata = '0, p1_wdata = '0;
  logic [7:0]  p0_rdata, p1_rdata;
  logic        p0_ack, p1_ack;
  logic        sclk, sram_ce, si, busy;
  logic        so = 1'b0;

  int total = 0;
  int bad = 0;
  int viol = 0;

  sram_spi_arbiter #(.ADDR_W(16), .CMD_READ(8'h03), .CMD_WRITE(8'h02)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(p0_rdata), .p0_ack(p0_ack),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_ack(p1_ack),
    .sclk(sclk), .sram_ce(sram_ce), .si(si), .so(so), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural SPI SRAM: shifts si in on sclk rising edges, drives read
  // data on falling edges after the 24 command/address bits, commits a
  // write only once all 32 bits have arrived.
  logic [7:0]  mem [0:65535];
  int          bitCnt = 0;
  int          capPulses = 0;
  logic [31:0] capFrame = '0;
  logic [7:0]  modelOp = '0;
  logic [15:0] modelAddr = '0;

  always @(negedge sram_ce) begin
    bitCnt    = 0;
    capPulses = 0;
    capFrame  = '0;
  end

  always @(posedge sclk) begin
    if (sram_ce === 1'b0) begin
      capFrame  = {capFrame[30:0], si};
      bitCnt    = bitCnt + 1;
      capPulses = capPulses + 1;
      if (bitCnt == 24) begin
        modelOp   = capFrame[23:16];
        modelAddr = capFrame[15:0];
      end
      if (bitCnt == 32 && modelOp == 8'h02) begin
        mem[modelAddr] = capFrame[7:0];
      end
    end
  end

  always @(negedge sclk) begin
    logic [7:0] b;
    if (sram_ce === 1'b0 && bitCnt >= 24 && bitCnt < 32 && modelOp == 8'h03) begin
      b  = mem[modelAddr];
      so = b[31 - bitCnt];
    end
  end

  // Bus rules that must hold at all times outside reset.
  always @(negedge clk) begin
    if (reset) begin
      if (sclk === 1'b1 && sram_ce === 1'b1) viol++;
      if (sram_ce === 1'b0 && busy === 1'b0) viol++;
    end
  end

  // Single comparison point: counts every check, reports any failure.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) checkOutput("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    p0_req = 1'b0;
    p1_req = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  // One access from a single port; reports ack latency (cycles after the
  // grant edge), number of cycles with sram_ce low, read byte, whether the
  // other port acked, and the other port's rdata at completion.
  task automatic applyStimulus(input int port, input logic we, input logic [15:0] addr,
                               input logic [7:0] wd, output int ackK, output int ceLow,
                               output logic [7:0] rd, output logic otherAck,
                               output logic [7:0] otherRd);
    waitIdle();
    if (port == 0) begin
      p0_we = we; p0_addr = addr; p0_wdata = wd; p0_req = 1'b1;
    end else begin
      p1_we = we; p1_addr = addr; p1_wdata = wd; p1_req = 1'b1;
    end
    ackK = -1; ceLow = 0; otherAck = 1'b0; rd = '0; otherRd = '0;
    for (int k = 1; k <= 150 && ackK < 0; k++) begin
      @(negedge clk);
      if (k == 2) begin
        // Requester-side changes after the grant must be ignored.
        if (port == 0) begin p0_addr = ~addr; p0_wdata = ~wd; end
        else begin p1_addr = ~addr; p1_wdata = ~wd; end
      end
      if (sram_ce === 1'b0) ceLow++;
      if ((port == 0 ? p1_ack : p0_ack) === 1'b1) otherAck = 1'b1;
      if ((port == 0 ? p0_ack : p1_ack) === 1'b1) begin
        ackK    = k;
        rd      = (port == 0) ? p0_rdata : p1_rdata;
        otherRd = (port == 0) ? p1_rdata : p0_rdata;
      end
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  expRd;
    logic        chkFrame;
    logic [31:0] expFrame;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int ackK, ceLow, p0K, p1K, nAck;
    logic [7:0] rd, otherRd, p1Rd;
    logic otherAck, sawAck;
    logic [7:0] lastRd [2];
    int order [3];
    logic [7:0] expRd;

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

    vecs[0] = '{0, 1'b1, 16'h0010, 8'hA5, 8'h00, 1'b1, 32'h020010A5};
    vecs[1] = '{1, 1'b0, 16'h0010, 8'h00, 8'hA5, 1'b1, 32'h03001000};
    vecs[2] = '{1, 1'b1, 16'h1234, 8'h3C, 8'h00, 1'b1, 32'h0212343C};
    vecs[3] = '{0, 1'b0, 16'h1234, 8'h00, 8'h3C, 1'b0, 32'h0};
    vecs[4] = '{0, 1'b1, 16'hFFFF, 8'h81, 8'h00, 1'b1, 32'h02FFFF81};
    vecs[5] = '{1, 1'b0, 16'hFFFF, 8'h00, 8'h81, 1'b0, 32'h0};
    vecs[6] = '{1, 1'b1, 16'h0000, 8'hFF, 8'h00, 1'b0, 32'h0};
    vecs[7] = '{0, 1'b0, 16'h0000, 8'h00, 8'hFF, 1'b1, 32'h03000000};
    vecs[8] = '{1, 1'b0, 16'h0010, 8'h00, 8'hA5, 1'b0, 32'h0};

    // Reset values, checked while reset is still asserted.
    repeat (3) @(negedge clk);
    checkOutput("rst_ce", sram_ce, 1);
    checkOutput("rst_sclk", sclk, 0);
    checkOutput("rst_si", si, 0);
    checkOutput("rst_acks", {p0_ack, p1_ack}, 0);
    checkOutput("rst_rdata", {p0_rdata, p1_rdata}, 0);
    checkOutput("rst_busy", busy, 0);
    reset = 1'b1;

    // Tie right after reset: p0 write then p1 read of the same byte.
    waitIdle();
    p0_we = 1'b1; p0_addr = 16'h0010; p0_wdata = 8'hA5; p0_req = 1'b1;
    p1_we = 1'b0; p1_addr = 16'h0010; p1_wdata = 8'h00; p1_req = 1'b1;
    p0K = -1; p1K = -1; p1Rd = '0;
    for (int k = 1; k <= 250 && p1K < 0; k++) begin
      @(negedge clk);
      if (p0_ack === 1'b1 && p0K < 0) begin p0K = k; p0_req = 1'b0; end
      if (p1_ack === 1'b1) begin p1K = k; p1Rd = p1_rdata; p1_req = 1'b0; end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    checkOutput("tie_p0_ack", p0K, 65);
    checkOutput("tie_p1_ack", p1K, 132);
    checkOutput("tie_p1_rdata", p1Rd, 8'hA5);

    // Table of single-port accesses, starting from fresh reset state.
    doReset();
    lastRd[0] = 8'h00;
    lastRd[1] = 8'h00;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    ackK, ceLow, rd, otherAck, otherRd);
      checkOutput($sformatf("v%0d_ack_lat", i), ackK, 65);
      checkOutput($sformatf("v%0d_ce_low", i), ceLow, 64);
      checkOutput($sformatf("v%0d_other_ack", i), otherAck, 0);
      expRd = vecs[i].we ? lastRd[vecs[i].port] : vecs[i].expRd;
      checkOutput($sformatf("v%0d_rdata", i), rd, expRd);
      lastRd[vecs[i].port] = expRd;
      checkOutput($sformatf("v%0d_other_rdata", i), otherRd, lastRd[1 - vecs[i].port]);
      if (vecs[i].chkFrame) begin
        checkOutput($sformatf("v%0d_frame", i), capFrame, vecs[i].expFrame);
        checkOutput($sformatf("v%0d_pulses", i), capPulses, 32);
      end
    end

    // Continuous contention: both ports hold req; grants must alternate.
    doReset();
    waitIdle();
    p0_we = 1'b0; p0_addr = 16'h0010; p0_req = 1'b1;
    p1_we = 1'b0; p1_addr = 16'h1234; p1_req = 1'b1;
    nAck = 0;
    order[0] = -1; order[1] = -1; order[2] = -1;
    for (int k = 0; k < 300 && nAck < 3; k++) begin
      @(negedge clk);
      if (p0_ack === 1'b1) begin order[nAck] = 0; nAck++; end
      else if (p1_ack === 1'b1) begin order[nAck] = 1; nAck++; end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    checkOutput("rr_grant0", order[0], 0);
    checkOutput("rr_grant1", order[1], 1);
    checkOutput("rr_grant2", order[2], 0);
    checkOutput("rr_p0_rdata", p0_rdata, 8'hA5);
    checkOutput("rr_p1_rdata", p1_rdata, 8'h3C);

    // Reset 30 cycles into a write frame must abort it completely.
    waitIdle();
    p0_we = 1'b1; p0_addr = 16'h1234; p0_wdata = 8'h99; p0_req = 1'b1;
    repeat (30) @(negedge clk);
    reset = 1'b0;
    p0_req = 1'b0;
    @(negedge clk);
    checkOutput("abort_ce", sram_ce, 1);
    checkOutput("abort_sclk", sclk, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_rdata", p0_rdata, 8'h00);
    reset = 1'b1;
    sawAck = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (p0_ack === 1'b1 || p1_ack === 1'b1) sawAck = 1'b1;
    end
    checkOutput("abort_no_ack", sawAck, 0);
    applyStimulus(1, 1'b0, 16'h1234, 8'h00, ackK, ceLow, rd, otherAck, otherRd);
    checkOutput("after_abort_lat", ackK, 65);
    checkOutput("after_abort_rdata", rd, 8'h3C);

    checkOutput("protocol_violations", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
